// File: rtl/cw305_reg_mailbox_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cw305_reg_mailbox_pkg
// Description : Register offsets, STATUS layout and CTRL bit positions shared
//               by the host<->core mailbox.
// Revision    : 1.0 - initial release
// ============================================================================
package cw305_reg_mailbox_pkg;

    // Register offsets within one channel's 4-address window
    typedef enum logic [1:0] {
        MBOX_TX_DATA = 2'd0,
        MBOX_RX_DATA = 2'd1,
        MBOX_STATUS  = 2'd2,
        MBOX_CTRL    = 2'd3
    } mbox_reg_e;

    typedef struct packed {
        logic [1:0] rsvd;
        logic       rx_udf;
        logic       tx_ovf;
        logic       rx_full;
        logic       rx_empty;
        logic       tx_full;
        logic       tx_empty;
    } mbox_status_t;

    localparam int c_ST_TX_EMPTY = 0;
    localparam int c_ST_TX_FULL  = 1;
    localparam int c_ST_RX_EMPTY = 2;
    localparam int c_ST_RX_FULL  = 3;
    localparam int c_ST_TX_OVF   = 4;
    localparam int c_ST_RX_UDF   = 5;

    localparam int c_CTRL_FLUSH_TX = 0;
    localparam int c_CTRL_FLUSH_RX = 1;
    localparam int c_CTRL_CLR_ERR  = 2;
    localparam int c_CTRL_IRQ_EN   = 3;

endpackage
`default_nettype wire

// File: rtl/cw305_mbox_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cw305_mbox_fifo
// Description : Synchronous first-word-fall-through FIFO with flush and count.
// Revision    : 1.0 - initial release
// ============================================================================
module cw305_mbox_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [WIDTH-1:0]             o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Full comes from the registered count, so a same-cycle pop never frees room
    assign o_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full  & ~i_flush;
    assign w_pop_ok  = i_pop  & ~o_empty & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + c_CW'(w_push_ok) - c_CW'(w_pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/cw305_reg_mailbox.sv
`default_nettype none
// ============================================================================
// Module      : cw305_reg_mailbox
// Description : Multi-channel host<->core mailbox on the byte-wide register bus.
// Revision    : 1.0 - initial release
// ============================================================================
module cw305_reg_mailbox
    import cw305_reg_mailbox_pkg::*;
#(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pNUM_CH       = 2,
    parameter int pDATA_WIDTH   = 32,
    parameter int pFIFO_DEPTH   = 4,
    parameter int pBASE_ADDR    = 'h10
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_n_i,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    input  logic [7:0]                           write_data,
    output logic [7:0]                           read_data,
    input  logic                                 reg_read,
    input  logic                                 reg_write,
    input  logic                                 reg_addrvalid,
    output logic [pNUM_CH-1:0]                   O_tx_valid,
    output logic [pNUM_CH*pDATA_WIDTH-1:0]       O_tx_data,
    input  logic [pNUM_CH-1:0]                   I_tx_ready,
    input  logic [pNUM_CH-1:0]                   I_rx_valid,
    input  logic [pNUM_CH*pDATA_WIDTH-1:0]       I_rx_data,
    output logic [pNUM_CH-1:0]                   O_rx_ready,
    output logic                                 O_host_irq
);
    localparam int c_AW     = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int c_NBYTES = pDATA_WIDTH / 8;
    localparam int c_CW     = $clog2(pFIFO_DEPTH) + 1;

    logic                     w_wr;
    logic                     w_rd;
    logic                     w_byte_ok;
    logic                     w_last_byte;
    logic [pNUM_CH-1:0][7:0]  w_ch_rdata;
    logic [pNUM_CH-1:0]       w_irq;
    logic [7:0]               w_rdata;

    assign w_wr        = reg_addrvalid & reg_write;
    assign w_rd        = reg_addrvalid & reg_read;
    assign w_byte_ok   = (reg_bytecnt < pBYTECNT_SIZE'(c_NBYTES));
    assign w_last_byte = (reg_bytecnt == pBYTECNT_SIZE'(c_NBYTES - 1));

    for (genvar c = 0; c < pNUM_CH; c++) begin : g_ch
        localparam logic [c_AW-1:0] c_A_TX = c_AW'(pBASE_ADDR + 4*c + int'(MBOX_TX_DATA));
        localparam logic [c_AW-1:0] c_A_RX = c_AW'(pBASE_ADDR + 4*c + int'(MBOX_RX_DATA));
        localparam logic [c_AW-1:0] c_A_ST = c_AW'(pBASE_ADDR + 4*c + int'(MBOX_STATUS));
        localparam logic [c_AW-1:0] c_A_CT = c_AW'(pBASE_ADDR + 4*c + int'(MBOX_CTRL));

        logic                   w_sel_tx, w_sel_rx, w_sel_st, w_sel_ct;
        logic                   w_tx_push, w_ctrl_wr, w_tx_flush, w_rx_flush, w_clr_err;
        logic                   w_rx_rd, w_rx_pop, w_ovf_set, w_udf_set;
        logic                   w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
        logic [c_CW-1:0]        w_tx_count, w_rx_count;
        logic [pDATA_WIDTH-1:0] w_tx_head, w_rx_head, w_asm_next;
        logic [pDATA_WIDTH-1:0] r_asm;
        logic                   r_tx_ovf, r_rx_udf, r_irq_en, r_pop_armed;
        mbox_status_t           w_status;

        assign w_sel_tx   = (reg_address == c_A_TX);
        assign w_sel_rx   = (reg_address == c_A_RX);
        assign w_sel_st   = (reg_address == c_A_ST);
        assign w_sel_ct   = (reg_address == c_A_CT);
        assign w_tx_push  = w_wr & w_sel_tx & w_last_byte;
        assign w_ctrl_wr  = w_wr & w_sel_ct & (reg_bytecnt == '0);
        assign w_tx_flush = w_ctrl_wr & write_data[c_CTRL_FLUSH_TX];
        assign w_rx_flush = w_ctrl_wr & write_data[c_CTRL_FLUSH_RX];
        assign w_clr_err  = w_ctrl_wr & write_data[c_CTRL_CLR_ERR];
        assign w_rx_rd    = w_rd & w_sel_rx & w_byte_ok;
        // Pop fires once, on the first idle cycle after the last byte was read
        assign w_rx_pop   = r_pop_armed & ~reg_read;
        assign w_ovf_set  = w_tx_push & w_tx_full & ~w_tx_flush;
        assign w_udf_set  = w_rx_rd & w_rx_empty;

        always_comb begin
            w_asm_next = r_asm;
            for (int b = 0; b < c_NBYTES; b++) begin
                if (reg_bytecnt == pBYTECNT_SIZE'(b)) w_asm_next[8*b +: 8] = write_data;
            end
        end

        always_ff @(posedge usb_clk or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_asm       <= '0;
                r_tx_ovf    <= 1'b0;
                r_rx_udf    <= 1'b0;
                r_irq_en    <= 1'b0;
                r_pop_armed <= 1'b0;
            end else begin
                if (w_wr && w_sel_tx && w_byte_ok) r_asm <= w_asm_next;
                if (w_ctrl_wr) r_irq_en <= write_data[c_CTRL_IRQ_EN];
                r_tx_ovf <= w_ovf_set | (r_tx_ovf & ~w_clr_err);
                r_rx_udf <= w_udf_set | (r_rx_udf & ~w_clr_err);
                if (w_rx_flush || w_rx_pop)
                    r_pop_armed <= 1'b0;
                else if (w_rx_rd && w_last_byte && !w_rx_empty)
                    r_pop_armed <= 1'b1;
            end
        end

        cw305_mbox_fifo #(.WIDTH(pDATA_WIDTH), .DEPTH(pFIFO_DEPTH)) u_tx_fifo (
            .clk         (usb_clk),
            .rst_n       (reset_n_i),
            .i_push      (w_tx_push),
            .i_push_data (w_asm_next),
            .i_pop       (I_tx_ready[c]),
            .i_flush     (w_tx_flush),
            .o_head      (w_tx_head),
            .o_full      (w_tx_full),
            .o_empty     (w_tx_empty),
            .o_count     (w_tx_count)
        );

        cw305_mbox_fifo #(.WIDTH(pDATA_WIDTH), .DEPTH(pFIFO_DEPTH)) u_rx_fifo (
            .clk         (usb_clk),
            .rst_n       (reset_n_i),
            .i_push      (I_rx_valid[c]),
            .i_push_data (I_rx_data[c*pDATA_WIDTH +: pDATA_WIDTH]),
            .i_pop       (w_rx_pop),
            .i_flush     (w_rx_flush),
            .o_head      (w_rx_head),
            .o_full      (w_rx_full),
            .o_empty     (w_rx_empty),
            .o_count     (w_rx_count)
        );

        assign w_status = '{rsvd: 2'b00, rx_udf: r_rx_udf, tx_ovf: r_tx_ovf,
                            rx_full: w_rx_full, rx_empty: w_rx_empty,
                            tx_full: w_tx_full, tx_empty: w_tx_empty};

        always_comb begin
            w_ch_rdata[c] = 8'h00;
            if (w_sel_rx && !w_rx_empty) begin
                for (int b = 0; b < c_NBYTES; b++) begin
                    if (reg_bytecnt == pBYTECNT_SIZE'(b)) w_ch_rdata[c] = w_rx_head[8*b +: 8];
                end
            end else if (w_sel_st) begin
                if (reg_bytecnt == pBYTECNT_SIZE'(0))      w_ch_rdata[c] = w_status;
                else if (reg_bytecnt == pBYTECNT_SIZE'(1)) w_ch_rdata[c] = 8'(w_tx_count);
                else if (reg_bytecnt == pBYTECNT_SIZE'(2)) w_ch_rdata[c] = 8'(w_rx_count);
            end else if (w_sel_ct && reg_bytecnt == '0) begin
                w_ch_rdata[c][c_CTRL_IRQ_EN] = r_irq_en;
            end
        end

        assign O_tx_valid[c]                              = ~w_tx_empty;
        assign O_tx_data[c*pDATA_WIDTH +: pDATA_WIDTH]    = w_tx_head;
        assign O_rx_ready[c]                              = ~w_rx_full;
        assign w_irq[c]                                   = ~w_rx_empty & r_irq_en;
    end

    always_comb begin
        w_rdata = 8'h00;
        for (int c = 0; c < pNUM_CH; c++) w_rdata = w_rdata | w_ch_rdata[c];
    end

    always_ff @(posedge usb_clk or negedge reset_n_i) begin
        if (!reset_n_i) read_data <= 8'h00;
        else            read_data <= w_rd ? w_rdata : 8'h00;
    end

    assign O_host_irq = |w_irq;

endmodule
`default_nettype wire
